// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI command RAM: opcode encoding and the
// wrap-around address increment used by both address pointers.
package spi_ram_pkg;

   typedef enum logic [1:0] {
      OP_SET_WADDR = 2'b00,
      OP_WRITE     = 2'b01,
      OP_SET_RADDR = 2'b10,
      OP_READ      = 2'b11
   } op_e;

   // Next address in a circular buffer of 'depth' words.
   function automatic int unsigned wrap_inc(input int unsigned addr,
                                            input int unsigned depth);
      return (addr == depth - 1) ? 0 : addr + 1;
   endfunction

endpackage

// File: rtl/sp_sync_ram.sv
// Single-port-write RAM with a combinationally addressed read that is captured
// into a resettable output register; the array itself is never reset.
module sp_sync_ram #(
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [ADDR_SIZE-1:0] waddr,
   input  logic [DATA_SIZE-1:0] wdata,
   input  logic                 re,
   input  logic [ADDR_SIZE-1:0] raddr,
   output logic [DATA_SIZE-1:0] rdata
);

   logic [DATA_SIZE-1:0] mem [MEM_DEPTH];
   logic [DATA_SIZE-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/spi_cmd_ram.sv
// Command-decoded RAM behind the SPI slave: address/data commands, optional
// burst auto-increment, registered read with valid/ready, sticky error flags.
module spi_cmd_ram
   import spi_ram_pkg::*;
#(
   parameter  int unsigned ADDR_SIZE = 8,
   parameter  int unsigned DATA_SIZE = 8,
   parameter  int unsigned MEM_DEPTH = 256,
   parameter  int unsigned AUTO_INC  = 1,
   localparam int unsigned PAYLOAD_W = (ADDR_SIZE > DATA_SIZE) ? ADDR_SIZE : DATA_SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PAYLOAD_W+1:0] din,
   input  logic                 rx_valid,
   input  logic                 tx_ready,
   output logic [DATA_SIZE-1:0] dout,
   output logic                 tx_valid,
   output logic                 addr_err,
   output logic                 rd_ovf,
   input  logic                 clr_err
);

   localparam logic [ADDR_SIZE:0] DEPTH_LIM = (ADDR_SIZE + 1)'(MEM_DEPTH);

   op_e                  op;
   logic [ADDR_SIZE-1:0] addr_pl;
   logic [DATA_SIZE-1:0] data_pl;
   logic                 in_range;
   logic                 is_read, rd_accept, wr_en;

   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 addr_err_q, addr_err_d;
   logic                 rd_ovf_q, rd_ovf_d;

   assign op       = op_e'(din[PAYLOAD_W+1:PAYLOAD_W]);
   assign addr_pl  = din[ADDR_SIZE-1:0];
   assign data_pl  = din[DATA_SIZE-1:0];
   assign in_range = {1'b0, addr_pl} < DEPTH_LIM;
   assign is_read  = rx_valid && (op == OP_READ);
   // The slot is free if empty or being drained this very cycle.
   assign rd_accept = is_read && (!tx_valid_q || tx_ready);
   assign wr_en     = rx_valid && (op == OP_WRITE);

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      addr_err_d = addr_err_q && !clr_err;
      rd_ovf_d   = rd_ovf_q && !clr_err;
      tx_valid_d = tx_valid_q;

      if (rx_valid) begin
         unique case (op)
            OP_SET_WADDR: begin
               if (in_range) wr_addr_d = addr_pl;
               else          addr_err_d = 1'b1;
            end
            OP_WRITE: begin
               if (AUTO_INC != 0) wr_addr_d = ADDR_SIZE'(wrap_inc(32'(wr_addr_q), MEM_DEPTH));
            end
            OP_SET_RADDR: begin
               if (in_range) rd_addr_d = addr_pl;
               else          addr_err_d = 1'b1;
            end
            OP_READ: begin
               if (rd_accept) begin
                  if (AUTO_INC != 0) rd_addr_d = ADDR_SIZE'(wrap_inc(32'(rd_addr_q), MEM_DEPTH));
               end else begin
                  rd_ovf_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (rd_accept)     tx_valid_d = 1'b1;
      else if (tx_ready) tx_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         tx_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
         rd_ovf_q   <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         tx_valid_q <= tx_valid_d;
         addr_err_q <= addr_err_d;
         rd_ovf_q   <= rd_ovf_d;
      end
   end

   sp_sync_ram #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_SIZE (ADDR_SIZE),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .waddr (wr_addr_q),
      .wdata (data_pl),
      .re    (rd_accept),
      .raddr (rd_addr_q),
      .rdata (dout)
   );

   assign tx_valid = tx_valid_q;
   assign addr_err = addr_err_q;
   assign rd_ovf   = rd_ovf_q;

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Bench for spi_cmd_ram: two instances (burst and fixed addressing) sharing one
// stimulus stream, checked every cycle against an array/queue-level model.
module tb_spi_cmd_ram;

   localparam int DEPTH = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] din = '0;
   logic       rx_valid = 1'b0;
   logic       tx_ready = 1'b0;
   logic       clr_err = 1'b0;

   logic [7:0] dout     [2];
   logic       tx_valid [2];
   logic       addr_err [2];
   logic       rd_ovf   [2];

   spi_cmd_ram #(.ADDR_SIZE(8), .DATA_SIZE(8), .MEM_DEPTH(DEPTH), .AUTO_INC(1)) u_inc (
      .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
      .dout(dout[0]), .tx_valid(tx_valid[0]), .addr_err(addr_err[0]), .rd_ovf(rd_ovf[0]),
      .clr_err(clr_err));

   spi_cmd_ram #(.ADDR_SIZE(8), .DATA_SIZE(8), .MEM_DEPTH(DEPTH), .AUTO_INC(0)) u_fix (
      .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
      .dout(dout[1]), .tx_valid(tx_valid[1]), .addr_err(addr_err[1]), .rd_ovf(rd_ovf[1]),
      .clr_err(clr_err));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   // Reference model; index 0 = auto-increment, 1 = fixed addressing.
   int m_wr [2];
   int m_rd [2];
   int m_dout [2];
   bit m_tv [2];
   bit m_ae [2];
   bit m_ov [2];
   bit m_dk [2];
   int mem [2][DEPTH];
   bit wv  [2][DEPTH];

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_wr[k] = 0; m_rd[k] = 0; m_dout[k] = 0;
         m_tv[k] = 0; m_ae[k] = 0; m_ov[k] = 0; m_dk[k] = 1;
      end
   endfunction

   function automatic void model_step();
      int op, pl;
      bit acc;
      op = int'(din[9:8]);
      pl = int'(din[7:0]);
      for (int k = 0; k < 2; k++) begin
         acc = 0;
         if (clr_err) begin m_ae[k] = 0; m_ov[k] = 0; end
         if (rx_valid) begin
            case (op)
               0: if (pl < DEPTH) m_wr[k] = pl; else m_ae[k] = 1;
               1: begin
                  mem[k][m_wr[k]] = pl;
                  wv[k][m_wr[k]]  = 1;
                  if (k == 0) m_wr[k] = (m_wr[k] + 1) % DEPTH;
               end
               2: if (pl < DEPTH) m_rd[k] = pl; else m_ae[k] = 1;
               default: begin
                  if (!m_tv[k] || tx_ready) begin
                     acc = 1;
                     m_dout[k] = mem[k][m_rd[k]];
                     m_dk[k]   = wv[k][m_rd[k]];
                     m_tv[k]   = 1;
                     if (k == 0) m_rd[k] = (m_rd[k] + 1) % DEPTH;
                  end else begin
                     m_ov[k] = 1;
                  end
               end
            endcase
         end
         if (!acc && tx_ready) m_tv[k] = 0;
      end
   endfunction

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("tx_valid", k, tx_valid[k], m_tv[k]);
         chk("addr_err", k, addr_err[k], m_ae[k]);
         chk("rd_ovf", k, rd_ovf[k], m_ov[k]);
         if (m_dk[k]) chk("dout", k, dout[k], m_dout[k]);
      end
   end

   task automatic cmd(input logic [1:0] op, input logic [7:0] pl, input logic rdy);
      din = {op, pl}; rx_valid = 1'b1; tx_ready = rdy; clr_err = 1'b0;
      @(posedge clk); #2;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input logic rdy, input logic clr);
      rx_valid = 1'b0; tx_ready = rdy; clr_err = clr;
      @(posedge clk); #2;
      clr_err = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
         chk("rst_tv", k, tx_valid[k], 0);
         chk("rst_dout", k, dout[k], 0);
         chk("rst_ae", k, addr_err[k], 0);
         chk("rst_ov", k, rd_ovf[k], 0);
      end
      rst_n = 1'b1;
      idle(1'b0, 1'b0);

      // Burst write then read
      cmd(2'b00, 8'h10, 1'b1);
      cmd(2'b01, 8'hA1, 1'b1);
      cmd(2'b01, 8'hB2, 1'b1);
      cmd(2'b01, 8'hC3, 1'b1);
      cmd(2'b10, 8'h10, 1'b1);
      cmd(2'b11, 8'h00, 1'b1);
      chk("burst0", 0, dout[0], 8'hA1); chk("burst_tv", 0, tx_valid[0], 1);
      chk("fix0", 1, dout[1], 8'hC3);
      cmd(2'b11, 8'h00, 1'b1);
      chk("burst1", 0, dout[0], 8'hB2); chk("burst_tv", 0, tx_valid[0], 1);
      cmd(2'b11, 8'h00, 1'b1);
      chk("burst2", 0, dout[0], 8'hC3); chk("burst_tv", 0, tx_valid[0], 1);
      idle(1'b1, 1'b0);
      chk("drain_tv", 0, tx_valid[0], 0);

      // Wrap at MEM_DEPTH-1
      cmd(2'b00, 8'd199, 1'b1);
      cmd(2'b01, 8'h55, 1'b1);
      cmd(2'b01, 8'h66, 1'b1);
      cmd(2'b10, 8'd0, 1'b1);
      cmd(2'b11, 8'h00, 1'b1);
      chk("wrap", 0, dout[0], 8'h66); chk("wrap_ae", 0, addr_err[0], 0);
      idle(1'b1, 1'b0);

      // Range error leaves rd_addr alone
      cmd(2'b10, 8'h10, 1'b1);
      cmd(2'b10, 8'd250, 1'b1);
      chk("range_ae", 0, addr_err[0], 1); chk("range_ae", 1, addr_err[1], 1);
      idle(1'b0, 1'b1);
      chk("clr_ae", 0, addr_err[0], 0);
      cmd(2'b11, 8'h00, 1'b1);
      chk("range_rd", 0, dout[0], 8'hA1);
      idle(1'b1, 1'b0);

      // Backpressure
      cmd(2'b10, 8'h10, 1'b1);
      cmd(2'b11, 8'h00, 1'b0);
      repeat (3) begin
         idle(1'b0, 1'b0);
         chk("bp_hold", 0, dout[0], 8'hA1); chk("bp_tv", 0, tx_valid[0], 1);
      end
      cmd(2'b11, 8'h00, 1'b0);
      chk("bp_ovf", 0, rd_ovf[0], 1); chk("bp_dout", 0, dout[0], 8'hA1);
      idle(1'b1, 1'b0);
      cmd(2'b11, 8'h00, 1'b1);
      chk("bp_next", 0, dout[0], 8'hB2); chk("bp_fix", 1, dout[1], 8'hC3);
      idle(1'b1, 1'b1);

      // Fixed addressing overwrites in place
      cmd(2'b00, 8'd6, 1'b1);
      cmd(2'b01, 8'h77, 1'b1);
      cmd(2'b00, 8'd5, 1'b1);
      cmd(2'b01, 8'h11, 1'b1);
      cmd(2'b01, 8'h22, 1'b1);
      cmd(2'b10, 8'd5, 1'b1);
      cmd(2'b11, 8'h00, 1'b1);
      chk("noinc5", 1, dout[1], 8'h22); chk("inc5", 0, dout[0], 8'h11);
      cmd(2'b10, 8'd6, 1'b1);
      cmd(2'b11, 8'h00, 1'b1);
      chk("noinc6", 1, dout[1], 8'h77); chk("inc6", 0, dout[0], 8'h22);
      idle(1'b1, 1'b0);

      // Async reset while output is occupied
      cmd(2'b10, 8'd250, 1'b1);
      cmd(2'b11, 8'h00, 1'b0);
      chk("pre_rst_tv", 0, tx_valid[0], 1);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("arst_tv", k, tx_valid[k], 0);
         chk("arst_dout", k, dout[k], 0);
         chk("arst_ae", k, addr_err[k], 0);
         chk("arst_ov", k, rd_ovf[k], 0);
      end
      #3 rst_n = 1'b1;
      @(posedge clk); #2;
      cmd(2'b01, 8'h5C, 1'b1);
      cmd(2'b11, 8'h00, 1'b1);
      chk("post_rst0", 0, dout[0], 8'h5C); chk("post_rst0", 1, dout[1], 8'h5C);
      cmd(2'b00, 8'd3, 1'b1);
      cmd(2'b01, 8'h9A, 1'b1);
      cmd(2'b10, 8'd3, 1'b1);
      cmd(2'b11, 8'h00, 1'b1);
      chk("post_rst3", 0, dout[0], 8'h9A); chk("post_rst3", 1, dout[1], 8'h9A);
      idle(1'b1, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rx_valid = ($urandom_range(0, 3) != 0);
         din      = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
         tx_ready = ($urandom_range(0, 2) != 0);
         clr_err  = ($urandom_range(0, 15) == 0);
         @(posedge clk); #2;
      end
      rx_valid = 1'b0; clr_err = 1'b0;
      idle(1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_cmd_ram.md
Name: spi_cmd_ram

Overview:
- Parametrised command-decoded synchronous RAM that sits behind the SPI slave shift register.
- Consumes framed words of {opcode[1:0], payload}: set write address, write data, set read address, read data.
- Successor features:
  - configurable address/data widths and depth
  - optional address auto-increment for burst transfers
  - registered read path with a valid/ready handshake toward the SPI transmitter
  - sticky error flags for out-of-range addresses and dropped reads

Parameters:
- ADDR_SIZE, 8, address width in bits.
- DATA_SIZE, 8, data word width in bits.
- MEM_DEPTH, 256, number of words; must satisfy 1 <= MEM_DEPTH <= 2**ADDR_SIZE.
- AUTO_INC, 1, when 1 the write address advances after each write and the read address advances after each accepted read.
- Derived localparam PAYLOAD_W = max(ADDR_SIZE, DATA_SIZE).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  PAYLOAD_W+2  frame: [PAYLOAD_W+1:PAYLOAD_W] is the opcode, low bits are the payload.
- rx_valid  input  1  din is valid this cycle; one command is consumed per cycle.
- tx_ready  input  1  transmitter accepts dout this cycle.
- dout  output  DATA_SIZE  read data, registered.
- tx_valid  output  1  dout holds valid read data.
- addr_err  output  1  sticky: an address-set command carried an address >= MEM_DEPTH.
- rd_ovf  output  1  sticky: a read command was dropped because the output was still occupied.
- clr_err  input  1  synchronous clear of addr_err and rd_ovf.

Behaviour:
- Reset (async, rst_n low):
  - wr_addr = 0, rd_addr = 0, dout = 0, tx_valid = 0, addr_err = 0, rd_ovf = 0.
  - Memory contents are NOT reset, so they are undefined until written.
- Commands are decoded only when rx_valid = 1; with rx_valid = 0 nothing changes except the tx handshake.
- Opcode 00, SET_WADDR:
  - If payload[ADDR_SIZE-1:0] < MEM_DEPTH, wr_addr takes it at the next edge.
  - Otherwise wr_addr is unchanged and addr_err is set.
- Opcode 01, WRITE:
  - mem[wr_addr] <= payload[DATA_SIZE-1:0] at the next edge.
  - If AUTO_INC = 1, wr_addr <= (wr_addr == MEM_DEPTH-1) ? 0 : wr_addr+1.
- Opcode 10, SET_RADDR: same range check and addr_err rule as SET_WADDR, applied to rd_addr.
- Opcode 11, READ:
  - Accepted when the output slot is free: tx_valid = 0, or tx_valid = 1 and tx_ready = 1 in the same cycle.
  - On accept: dout <= mem[rd_addr] and tx_valid <= 1 at the next edge, giving 1-cycle latency from the accepting edge.
  - If AUTO_INC = 1, rd_addr advances with the same wrap rule as wr_addr.
  - If not accepted: the command is dropped, rd_ovf is set, and rd_addr and dout are unchanged.
  - The payload is ignored.
- Output handshake:
  - tx_valid and dout hold stable until a cycle with tx_ready = 1.
  - tx_valid then clears at the next edge, unless a READ is accepted in that same cycle; in that case tx_valid stays 1 and dout updates, allowing back-to-back reads.
- Read-after-write: a READ in the cycle after a WRITE to the same address returns the new data. No forwarding is needed because only one command arrives per cycle.
- clr_err = 1 clears both sticky flags at the next edge. If an error event occurs in the same cycle, the set wins.
- Reset asserted mid-burst aborts immediately: tx_valid drops asynchronously and pending data is lost.

Decomposition:
- Shared package spi_ram_pkg holds:
  - the opcode constants OP_SET_WADDR = 2'b00, OP_WRITE = 2'b01, OP_SET_RADDR = 2'b10, OP_READ = 2'b11
  - a wrap-increment function of (addr, depth)
- Sub-module sp_sync_ram:
  - single-port write, asynchronous-address / registered-output read
  - parameters DATA_SIZE, ADDR_SIZE, MEM_DEPTH
  - no reset on the array
- spi_cmd_ram contains the decode, address registers, handshake and error logic.

Test Plan:
- Burst write then read, AUTO_INC = 1, defaults:
  - Stimulus: SET_WADDR 0x10; WRITE 0xA1, 0xB2, 0xC3; SET_RADDR 0x10; READ x3 with tx_ready = 1.
  - Response: dout 0xA1, 0xB2, 0xC3 on 3 consecutive cycles, each one cycle after its READ, with tx_valid high throughout.
- Wrap, MEM_DEPTH = 200:
  - Stimulus: SET_WADDR 199; WRITE 0x55, 0x66; SET_RADDR 0; READ.
  - Response: dout = 0x66 and addr_err = 0.
- Range error:
  - Stimulus: SET_RADDR 250 with MEM_DEPTH = 200.
  - Response: addr_err = 1, rd_addr unchanged. clr_err then clears it to 0.
- Backpressure:
  - Stimulus: READ with tx_ready = 0; hold tx_ready low 3 cycles; issue a second READ.
  - Response: dout stable, tx_valid = 1, second READ dropped, rd_ovf = 1, rd_addr advanced only once.
- AUTO_INC = 0:
  - Stimulus: SET_WADDR 5; WRITE 0x11; WRITE 0x22; READ at address 5.
  - Response: dout = 0x22, and address 6 is untouched.
- Async reset mid-burst:
  - Stimulus: assert rst_n low while tx_valid = 1.
  - Response: tx_valid, dout, addresses and flags are all 0 immediately; a subsequent SET_WADDR/WRITE/READ operates normally.
